// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART controller.
// Holds the status-register bit layout and the default register addresses.
package uart_mmio_pkg;

  // Status register single-bit fields
  localparam int ST_RXNE   = 0;  // RX FIFO holds at least one byte
  localparam int ST_TXNF   = 1;  // TX FIFO has a free slot
  localparam int ST_RXOVF  = 2;  // sticky: received byte lost to a full RX FIFO
  localparam int ST_TXDROP = 3;  // sticky: non-blocking store lost to a full TX FIFO

  // Status register count fields
  localparam int ST_RXCNT_LSB  = 8;
  localparam int ST_TXFREE_LSB = 16;
  localparam int ST_CNT_W      = 8;

  // Default word addresses
  localparam int DEF_DATA_ADDR = 0;
  localparam int DEF_STAT_ADDR = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (pointers and count only)
//   push  - write request; honoured when not full, or when full with a pop
//   din   - write data
//   pop   - read request; ignored when empty
//   dout  - current head entry (valid while !empty)
//   empty - no entries stored
//   full  - DEPTH entries stored
//   count - number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_pop;
  logic w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  assign w_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART controller on the core data-memory port.
// Buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO,
// exposes a status/control register, and raises a combinational stall
// for blocking accesses that cannot complete this cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   daddr, mre, mwe     - data address, load request, store request
//   wdata               - store data
//   rdata               - load data, combinational
//   hit                 - address selects the data or status register
//   stall               - hold the PC and register writeback
//   rx_byte, rx_strobe  - byte from the UART receiver, one-cycle valid
//   tx_byte, tx_valid   - byte offered to the UART transmitter
//   tx_ready            - transmitter takes tx_byte this cycle
module mmio_uart_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int DATA_ADDR = DEF_DATA_ADDR,
  parameter int STAT_ADDR = DEF_STAT_ADDR,
  parameter int BLOCKING  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              mre,
  input  logic              mwe,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              stall,
  input  logic [7:0]        rx_byte,
  input  logic              rx_strobe,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int  RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int  TX_CW = $clog2(TX_DEPTH) + 1;
  localparam logic BLK  = (BLOCKING != 0);

  logic             w_data_sel;
  logic             w_stat_sel;
  logic             w_stall;

  logic             w_rx_pop;
  logic [7:0]       w_rx_dout;
  logic             w_rx_empty;
  logic             w_rx_full;
  logic [RX_CW-1:0] w_rx_count;
  logic             w_rx_ovf_evt;

  logic             w_tx_push_req;
  logic             w_tx_pop;
  logic [7:0]       w_tx_dout;
  logic             w_tx_empty;
  logic             w_tx_full;
  logic [TX_CW-1:0] w_tx_count;
  logic [TX_CW-1:0] w_tx_free;
  logic             w_tx_drop_evt;

  logic             w_stat_wr;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;

  logic             r_rx_ovf;
  logic             r_tx_drop;

  logic             w_unused_wdata;

  assign w_data_sel = (daddr == ADDR_W'(DATA_ADDR));
  assign w_stat_sel = (daddr == ADDR_W'(STAT_ADDR));
  assign hit        = w_data_sel || w_stat_sel;

  // A full TX FIFO with tx_ready asserted frees its head this cycle, so the
  // store can complete without a stall.
  assign w_stall = BLK && ((mre && w_data_sel && w_rx_empty) ||
                           (mwe && w_data_sel && w_tx_full && !tx_ready));
  assign stall   = w_stall;

  // RX side: the load pops only when the whole access completes this cycle.
  assign w_rx_pop     = mre && w_data_sel && !w_rx_empty && !w_stall;
  assign w_rx_ovf_evt = rx_strobe && w_rx_full && !w_rx_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_strobe),
    .din   (rx_byte),
    .pop   (w_rx_pop),
    .dout  (w_rx_dout),
    .empty (w_rx_empty),
    .full  (w_rx_full),
    .count (w_rx_count)
  );

  // TX side: in non-blocking mode a store into a full FIFO (no pop) is lost.
  assign w_tx_pop      = !w_tx_empty && tx_ready;
  assign w_tx_push_req = mwe && w_data_sel && !w_stall;
  assign w_tx_drop_evt = w_tx_push_req && w_tx_full && !w_tx_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push_req),
    .din   (wdata[7:0]),
    .pop   (w_tx_pop),
    .dout  (w_tx_dout),
    .empty (w_tx_empty),
    .full  (w_tx_full),
    .count (w_tx_count)
  );

  assign tx_valid  = !w_tx_empty;
  // Stale storage is hidden so the transmitter sees zero when idle.
  assign tx_byte   = w_tx_empty ? 8'h00 : w_tx_dout;
  assign w_tx_free = TX_CW'(TX_DEPTH) - w_tx_count;

  always_comb begin
    w_status = '0;
    w_status[ST_RXNE]   = !w_rx_empty;
    w_status[ST_TXNF]   = !w_tx_full;
    w_status[ST_RXOVF]  = r_rx_ovf;
    w_status[ST_TXDROP] = r_tx_drop;
    w_status[ST_RXCNT_LSB  +: ST_CNT_W] = ST_CNT_W'(w_rx_count);
    w_status[ST_TXFREE_LSB +: ST_CNT_W] = ST_CNT_W'(w_tx_free);
  end

  always_comb begin
    w_rdata = '0;
    if (mre && w_data_sel) begin
      if (w_rx_empty) w_rdata = BLK ? '0 : '1;
      else            w_rdata = DATA_W'(w_rx_dout);
    end else if (mre && w_stat_sel) begin
      w_rdata = w_status;
    end
  end
  assign rdata = w_rdata;

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  assign w_stat_wr = mwe && w_stat_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ovf  <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_rx_ovf_evt)                         r_rx_ovf <= 1'b1;
      else if (w_stat_wr && wdata[ST_RXOVF])    r_rx_ovf <= 1'b0;
      if (w_tx_drop_evt)                        r_tx_drop <= 1'b1;
      else if (w_stat_wr && wdata[ST_TXDROP])   r_tx_drop <= 1'b0;
    end
  end

  // Upper store-data bits have no meaning for either register.
  assign w_unused_wdata = ^wdata[DATA_W-1:8];

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Blocking instance
  logic [24:0] daddr;
  logic        mre, mwe;
  logic [31:0] wdata, rdata;
  logic        hit, stall;
  logic [7:0]  rx_byte, tx_byte;
  logic        rx_strobe, tx_valid, tx_ready;
  // Non-blocking instance
  logic [24:0] nb_daddr;
  logic        nb_mre, nb_mwe;
  logic [31:0] nb_wdata, nb_rdata;
  logic        nb_hit, nb_stall;
  logic [7:0]  nb_rx_byte, nb_tx_byte;
  logic        nb_rx_strobe, nb_tx_valid, nb_tx_ready;

  mmio_uart_ctrl #(.BLOCKING(1)) u_blk (
    .clk(clk), .rst(rst), .daddr(daddr), .mre(mre), .mwe(mwe), .wdata(wdata),
    .rdata(rdata), .hit(hit), .stall(stall), .rx_byte(rx_byte),
    .rx_strobe(rx_strobe), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  mmio_uart_ctrl #(.BLOCKING(0)) u_nb (
    .clk(clk), .rst(rst), .daddr(nb_daddr), .mre(nb_mre), .mwe(nb_mwe),
    .wdata(nb_wdata), .rdata(nb_rdata), .hit(nb_hit), .stall(nb_stall),
    .rx_byte(nb_rx_byte), .rx_strobe(nb_rx_strobe), .tx_byte(nb_tx_byte),
    .tx_valid(nb_tx_valid), .tx_ready(nb_tx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] nbq[$];

  typedef struct {
    logic        mre, mwe;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall, hit, txv;
    logic [31:0] nb_rdata;
    logic        nb_stall;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transmit-side scoreboards: each accepted byte must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (txq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL tx_extra: got 0x%02h, want no byte", tx_byte);
      end else chk("tx_byte", {24'h0, tx_byte}, {24'h0, txq.pop_front()});
    end
    if (rst === 1'b0 && nb_tx_valid === 1'b1 && nb_tx_ready === 1'b1) begin
      if (nbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL nb_tx_extra: got 0x%02h, want no byte", nb_tx_byte);
      end else chk("nb_tx_byte", {24'h0, nb_tx_byte}, {24'h0, nbq.pop_front()});
    end
  end

  task automatic rx_send(input logic [7:0] b, input bit accepted);
    rx_strobe = 1'b1; rx_byte = b;
    if (accepted) rxq.push_back(b);
    tick;
    rx_strobe = 1'b0;
  endtask

  task automatic ld_data(input string name);
    int n;
    mre = 1'b1; daddr = 25'd0;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 50) begin tick; n++; end
    if (stall !== 1'b0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got stall=%b, want 0", name, stall);
    end else if (rxq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_noexp: got 0x%08h, want no data", name, rdata);
    end else chk(name, rdata, {24'h0, rxq.pop_front()});
    tick;
    mre = 1'b0;
  endtask

  task automatic rd_stat(input string name, input logic [31:0] exp);
    mre = 1'b1; daddr = 25'd1;
    #1;
    chk(name, rdata, exp);
    tick;
    mre = 1'b0;
  endtask

  task automatic st_data(input logic [7:0] b);
    mwe = 1'b1; daddr = 25'd0; wdata = {24'h0, b};
    #1;
    chk("st_stall", {31'h0, stall}, 32'h0);
    txq.push_back(b);
    tick;
    mwe = 1'b0;
  endtask

  task automatic nb_rd_stat(input string name, input logic [31:0] exp);
    nb_mre = 1'b1; nb_daddr = 25'd1;
    #1;
    chk(name, nb_rdata, exp);
    tick;
    nb_mre = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    daddr = '0; mre = 0; mwe = 0; wdata = '0; rx_byte = '0; rx_strobe = 0; tx_ready = 0;
    nb_daddr = '0; nb_mre = 0; nb_mwe = 0; nb_wdata = '0; nb_rx_byte = '0;
    nb_rx_strobe = 0; nb_tx_ready = 0;

    //                mre  mwe  addr    wdata        rdata        stl  hit  txv  nb_rdata     nb_stl
    vt[0] = '{1'b1, 1'b0, 25'd1, 32'h0,  32'h00100002, 1'b0, 1'b1, 1'b0, 32'h00100002, 1'b0};
    vt[1] = '{1'b1, 1'b0, 25'd0, 32'h0,  32'h00000000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
    vt[2] = '{1'b1, 1'b0, 25'd5, 32'h0,  32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vt[3] = '{1'b0, 1'b1, 25'd5, 32'hFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vt[4] = '{1'b0, 1'b1, 25'd1, 32'hC,  32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vt[5] = '{1'b0, 1'b0, 25'd0, 32'h0,  32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vt[6] = '{1'b1, 1'b0, 25'd1, 32'h0,  32'h00100002, 1'b0, 1'b1, 1'b0, 32'h00100002, 1'b0};
    vt[7] = '{1'b1, 1'b1, 25'd7, 32'h41, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};

    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_byte",  {24'h0, tx_byte},  32'h0);
    chk("rst_stall",    {31'h0, stall},    32'h0);
    chk("rst_rdata",    rdata,             32'h0);
    tick;

    // Table: stateless accesses applied to both instances
    for (int i = 0; i < 8; i++) begin
      mre = vt[i].mre; mwe = vt[i].mwe; daddr = vt[i].addr; wdata = vt[i].wdata;
      nb_mre = vt[i].mre; nb_mwe = vt[i].mwe; nb_daddr = vt[i].addr; nb_wdata = vt[i].wdata;
      #1;
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].rdata);
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].stall});
      chk($sformatf("v%0d_hit", i), {31'h0, hit}, {31'h0, vt[i].hit});
      chk($sformatf("v%0d_txv", i), {31'h0, tx_valid}, {31'h0, vt[i].txv});
      chk($sformatf("v%0d_nb_rdata", i), nb_rdata, vt[i].nb_rdata);
      chk($sformatf("v%0d_nb_stall", i), {31'h0, nb_stall}, {31'h0, vt[i].nb_stall});
      tick;
    end
    mre = 0; mwe = 0; nb_mre = 0; nb_mwe = 0; daddr = '0; nb_daddr = '0;

    // RX path and blocking load
    rx_send(8'h41, 1'b1);
    rx_send(8'h42, 1'b1);
    ld_data("t1_ld0");
    ld_data("t1_ld1");
    mre = 1'b1; daddr = 25'd0;
    #1;
    chk("t1_empty_stall", {31'h0, stall}, 32'h1);
    chk("t1_empty_rdata", rdata, 32'h0);
    tick;
    chk("t1_still_stall", {31'h0, stall}, 32'h1);
    rx_strobe = 1'b1; rx_byte = 8'h43; rxq.push_back(8'h43);
    #1;
    chk("t1_strobe_stall", {31'h0, stall}, 32'h1);
    tick;
    rx_strobe = 1'b0;
    #1;
    chk("t1_release_stall", {31'h0, stall}, 32'h0);
    chk("t1_ld2", rdata, {24'h0, rxq.pop_front()});
    tick;
    mre = 1'b0;
    rd_stat("t1_stat", 32'h00100002);

    // TX full with blocking store
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) st_data(8'(i));
    mwe = 1'b1; daddr = 25'd0; wdata = 32'h10;
    #1;
    chk("t2_full_stall", {31'h0, stall}, 32'h1);
    tick;
    chk("t2_full_stall2", {31'h0, stall}, 32'h1);
    tx_ready = 1'b1;
    #1;
    chk("t2_ready_stall", {31'h0, stall}, 32'h0);
    txq.push_back(8'h10);
    tick;
    tx_ready = 1'b0; mwe = 1'b0;
    rd_stat("t2_stat_full", 32'h00000000);
    chk("t2_txq_left", txq.size(), 32'd16);
    tx_ready = 1'b1;
    repeat (16) tick;
    tx_ready = 1'b0;
    #1;
    chk("t2_drained_txv", {31'h0, tx_valid}, 32'h0);
    chk("t2_txq_empty", txq.size(), 32'd0);
    rd_stat("t2_stat_empty", 32'h00100002);

    // RX overflow, sticky flag, set-wins and same-address load/store
    for (int i = 0; i < 17; i++) rx_send(8'(8'h50 + i), i < 16);
    rd_stat("t3_stat_ovf", 32'h00101007);
    rx_strobe = 1'b1; rx_byte = 8'h70; mwe = 1'b1; daddr = 25'd1; wdata = 32'h4;
    tick;
    rx_strobe = 1'b0; mwe = 1'b0;
    rd_stat("t3_setwins", 32'h00101007);
    mre = 1'b1; mwe = 1'b1; daddr = 25'd1; wdata = 32'h4;
    #1;
    chk("t3_ldst_prestore", rdata, 32'h00101007);
    tick;
    mre = 1'b0; mwe = 1'b0;
    rd_stat("t3_stat_clr", 32'h00101003);

    // Pop and push together on a full RX FIFO
    mre = 1'b1; daddr = 25'd0; rx_strobe = 1'b1; rx_byte = 8'h61;
    #1;
    chk("t5_stall", {31'h0, stall}, 32'h0);
    chk("t5_head", rdata, {24'h0, rxq.pop_front()});
    rxq.push_back(8'h61);
    tick;
    mre = 1'b0; rx_strobe = 1'b0;
    rd_stat("t5_stat", 32'h00101003);
    for (int i = 0; i < 16; i++) ld_data($sformatf("t5_ld%0d", i));
    rd_stat("t5_stat_empty", 32'h00100002);

    // Non-blocking instance: empty load and dropped store
    nb_mre = 1'b1; nb_daddr = 25'd0;
    #1;
    chk("t4_nb_empty_rdata", nb_rdata, 32'hFFFFFFFF);
    chk("t4_nb_empty_stall", {31'h0, nb_stall}, 32'h0);
    tick;
    nb_mre = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nb_mwe = 1'b1; nb_daddr = 25'd0; nb_wdata = 32'(8'hA0 + i);
      nbq.push_back(8'(8'hA0 + i));
      tick;
    end
    nb_wdata = 32'hEE;
    #1;
    chk("t4_nb_full_stall", {31'h0, nb_stall}, 32'h0);
    tick;
    nb_mwe = 1'b0;
    nb_rd_stat("t4_nb_stat_drop", 32'h00000008);
    nb_tx_ready = 1'b1;
    repeat (17) tick;
    nb_tx_ready = 1'b0;
    chk("t4_nbq_empty", nbq.size(), 32'd0);
    nb_rd_stat("t4_nb_stat_drained", 32'h0010000A);

    // Reset during buffered TX and a stalled load
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) st_data(8'(8'hC0 + i));
    mre = 1'b1; daddr = 25'd0;
    #1;
    chk("t6_stall_before", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0; mre = 1'b0;
    txq.delete();
    #1;
    chk("t6_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("t6_tx_byte", {24'h0, tx_byte}, 32'h0);
    chk("t6_stall", {31'h0, stall}, 32'h0);
    rd_stat("t6_stat", 32'h00100002);
    nb_rd_stat("t6_nb_stat", 32'h00100002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
